// File: rtl/instr_fetch_unit.sv
// Fetch/decode stage between the free-running PC and the datapath control unit.
// Control-flow opcodes are resolved locally; everything else is issued over valid/ready.
module instr_fetch_unit #(
  parameter int               ADDR_W    = 12,
  parameter int               INSTR_W   = 24,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [7:0]       OP_NOP    = 8'h00,
  parameter logic [7:0]       OP_JMP    = 8'h01,
  parameter logic [7:0]       OP_JZ     = 8'h02,
  parameter logic [7:0]       OP_HALT   = 8'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  i_pc_addr,
  output logic               o_pc_jmp,
  output logic [ADDR_W-1:0]  o_pc_jmp_addr,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [INSTR_W-1:0] i_rom_rdata,
  input  logic               i_zero_flag,
  output logic               o_issue_valid,
  input  logic               i_issue_ready,
  output logic [7:0]         o_issue_opcode,
  output logic [ADDR_W-1:0]  o_issue_operand,
  output logic               o_halted,
  output logic [15:0]        o_retired
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_issue_valid;
  logic [7:0]        r_issue_opcode;
  logic [ADDR_W-1:0] r_issue_operand;
  logic [15:0]       r_retired;

  logic [7:0]        w_opcode;
  logic [ADDR_W-1:0] w_operand;
  logic              w_retire;
  logic              w_capture;
  logic              w_pc_jmp;
  logic [ADDR_W-1:0] w_pc_jmp_addr;
  logic              w_unused_bits;

  assign w_opcode      = i_rom_rdata[INSTR_W-1 -: 8];
  assign w_operand     = i_rom_rdata[ADDR_W-1:0];
  assign w_unused_bits = ^i_rom_rdata[INSTR_W-9:ADDR_W];

  assign o_rom_addr = i_pc_addr;

  // PC is held (jmp to itself) unless a state explicitly lets it advance or redirects it.
  always_comb begin
    w_next_state  = r_state;
    w_pc_jmp      = 1'b1;
    w_pc_jmp_addr = i_pc_addr;
    w_retire      = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
        if (w_opcode == OP_NOP) begin
          w_pc_jmp = 1'b0;
        end else if (w_opcode == OP_JMP) begin
          w_pc_jmp_addr = w_operand;
        end else if (w_opcode == OP_JZ) begin
          if (i_zero_flag) w_pc_jmp_addr = w_operand;
          else             w_pc_jmp      = 1'b0;
        end else if (w_opcode == OP_HALT) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_ISSUE;
          w_retire     = 1'b0;
          w_capture    = 1'b1;
        end
      end
      S_ISSUE: begin
        if (r_issue_valid && i_issue_ready) begin
          w_pc_jmp     = 1'b0;
          w_retire     = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      default: w_next_state = S_HALT;
    endcase
  end

  // Reset overrides combinationally so every edge during reset loads RESET_VEC.
  assign o_pc_jmp      = rst_n ? w_pc_jmp      : 1'b1;
  assign o_pc_jmp_addr = rst_n ? w_pc_jmp_addr : RESET_VEC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_FETCH;
      r_issue_valid   <= 1'b0;
      r_issue_opcode  <= '0;
      r_issue_operand <= '0;
      r_retired       <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_retired <= r_retired + 16'd1;
      if (w_capture) begin
        r_issue_valid   <= 1'b1;
        r_issue_opcode  <= w_opcode;
        r_issue_operand <= w_operand;
      end else if (r_state == S_ISSUE && i_issue_ready) begin
        r_issue_valid <= 1'b0;
      end
    end
  end

  assign o_issue_valid   = r_issue_valid;
  assign o_issue_opcode  = r_issue_opcode;
  assign o_issue_operand = r_issue_operand;
  assign o_halted        = (r_state == S_HALT);
  assign o_retired       = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: a behavioural PC and synchronous ROM surround the fetch unit.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pc = 12'h123;
  logic        pc_jmp;
  logic [11:0] pc_jmp_addr;
  logic [11:0] rom_addr;
  logic [23:0] rom_rdata = '0;
  logic        zero_flag = 1'b0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [7:0]  issue_opcode;
  logic [11:0] issue_operand;
  logic        halted;
  logic [15:0] retired;
  logic [23:0] rom [4096];
  int          n_pass = 0;
  int          n_total = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .i_pc_addr(pc), .o_pc_jmp(pc_jmp), .o_pc_jmp_addr(pc_jmp_addr),
    .o_rom_addr(rom_addr), .i_rom_rdata(rom_rdata), .i_zero_flag(zero_flag),
    .o_issue_valid(issue_valid), .i_issue_ready(issue_ready),
    .o_issue_opcode(issue_opcode), .o_issue_operand(issue_operand),
    .o_halted(halted), .o_retired(retired)
  );

  always #5 clk = ~clk;

  // Free-running PC and synchronous ROM
  always @(posedge clk) begin
    pc        <= pc_jmp ? pc_jmp_addr : 12'(pc + 12'd1);
    rom_rdata <= rom[rom_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++; if (pc_jmp !== 1'b1) $display("FAIL rst_pc_jmp got %h want 1", pc_jmp); else n_pass++;
    n_total++; if (pc_jmp_addr !== 12'h000) $display("FAIL rst_pc_jmp_addr got %h want 000", pc_jmp_addr); else n_pass++;
    tick();
    n_total++; if (pc !== 12'h000) $display("FAIL rst_pc got %h want 000", pc); else n_pass++;
    n_total++; if ({issue_valid, halted, issue_opcode, issue_operand, retired} !== '0)
      $display("FAIL rst_outputs got v=%b h=%b op=%h opd=%h ret=%h want all 0",
               issue_valid, halted, issue_opcode, issue_operand, retired);
    else n_pass++;
  endtask

  task automatic test_nop();
    logic [11:0] exp_pc [5];
    bit          saw_valid;
    exp_pc[0] = 12'h000; exp_pc[1] = 12'h000; exp_pc[2] = 12'h001; exp_pc[3] = 12'h001; exp_pc[4] = 12'h002;
    saw_valid = 1'b0;
    rom[0] = 24'h000000; rom[1] = 24'h000000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_total++; if (pc !== exp_pc[i]) $display("FAIL nop_pc[%0d] got %h want %h", i, pc, exp_pc[i]); else n_pass++;
      if (issue_valid !== 1'b0) saw_valid = 1'b1;
      if (i < 4) tick();
    end
    n_total++; if (retired !== 16'd2) $display("FAIL nop_retired got %0d want 2", retired); else n_pass++;
    n_total++; if (saw_valid) $display("FAIL nop_no_issue got valid=1 want 0"); else n_pass++;
  endtask

  task automatic test_issue_stall();
    rom[0] = 24'h10F0AB;  // upper operand nibble must be dropped
    issue_ready = 1'b0;
    do_reset();
    tick();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL iss_decode_valid got %b want 0", issue_valid); else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) issue_ready = 1'b1;
      #1;
      n_total++;
      if ({issue_valid, issue_opcode, issue_operand, pc} !== {1'b1, 8'h10, 12'h0AB, 12'h000})
        $display("FAIL iss_hold[%0d] got v=%b op=%h opd=%h pc=%h want 1 10 0ab 000",
                 i, issue_valid, issue_opcode, issue_operand, pc);
      else n_pass++;
      tick();
    end
    issue_ready = 1'b0;
    n_total++;
    if ({issue_valid, pc, retired} !== {1'b0, 12'h001, 16'd1})
      $display("FAIL iss_accept got v=%b pc=%h ret=%0d want 0 001 1", issue_valid, pc, retired);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // Opcode FE is one bit off HALT and must be issued; ready already high gives 3 cycles.
    rom[0] = 24'hFE0123; rom[1] = 24'h030456;
    issue_ready = 1'b1;
    do_reset();
    tick(); tick();
    n_total++; if ({issue_valid, issue_opcode, issue_operand} !== {1'b1, 8'hFE, 12'h123})
      $display("FAIL b2b_first got v=%b op=%h opd=%h want 1 fe 123", issue_valid, issue_opcode, issue_operand);
    else n_pass++;
    tick();
    n_total++; if ({pc, halted} !== {12'h001, 1'b0}) $display("FAIL b2b_pc got pc=%h h=%b want 001 0", pc, halted); else n_pass++;
    tick(); tick();
    n_total++; if ({issue_valid, issue_opcode, issue_operand} !== {1'b1, 8'h03, 12'h456})
      $display("FAIL b2b_second got v=%b op=%h opd=%h want 1 03 456", issue_valid, issue_opcode, issue_operand);
    else n_pass++;
    tick();
    n_total++; if ({pc, retired} !== {12'h002, 16'd2}) $display("FAIL b2b_done got pc=%h ret=%0d want 002 2", pc, retired); else n_pass++;
    issue_ready = 1'b0;
  endtask

  task automatic test_jmp_wrap();
    logic [11:0] exp_pc [4];
    exp_pc[0] = 12'h000; exp_pc[1] = 12'hFFE; exp_pc[2] = 12'hFFF; exp_pc[3] = 12'h000;
    rom[0] = 24'h010FFE; rom[12'hFFE] = 24'h000000; rom[12'hFFF] = 24'h000000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      n_total++; if (pc !== exp_pc[i]) $display("FAIL jmp_pc[%0d] got %h want %h", i, pc, exp_pc[i]); else n_pass++;
      tick(); tick();
    end
    n_total++; if (retired !== 16'd4) $display("FAIL jmp_retired got %0d want 4", retired); else n_pass++;
  endtask

  task automatic test_jz();
    rom[0] = 24'h020040;
    zero_flag = 1'b0;
    do_reset();
    zero_flag = 1'b1;
    tick();
    zero_flag = 1'b1;
    tick();
    n_total++; if (pc !== 12'h040) $display("FAIL jz_taken got %h want 040", pc); else n_pass++;
    zero_flag = 1'b1;  // only the DECODE-cycle value matters
    do_reset();
    tick();
    zero_flag = 1'b0;
    tick();
    n_total++; if ({pc, retired} !== {12'h001, 16'd1}) $display("FAIL jz_not_taken got pc=%h ret=%0d want 001 1", pc, retired); else n_pass++;
  endtask

  task automatic test_self_loop();
    rom[0] = 24'h010000;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    n_total++; if ({pc, retired} !== {12'h000, 16'd3}) $display("FAIL loop got pc=%h ret=%0d want 000 3", pc, retired); else n_pass++;
  endtask

  task automatic test_halt();
    bit bad;
    bad = 1'b0;
    rom[0] = 24'hFF0000;
    do_reset();
    tick();
    n_total++; if (halted !== 1'b0) $display("FAIL halt_early got %b want 0", halted); else n_pass++;
    tick();
    for (int i = 0; i < 20; i++) begin
      if (halted !== 1'b1 || pc !== 12'h000 || issue_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    n_total++; if (bad) $display("FAIL halt_hold got h=%b pc=%h v=%b want 1 000 0", halted, pc, issue_valid); else n_pass++;
    n_total++; if (retired !== 16'd1) $display("FAIL halt_retired got %0d want 1", retired); else n_pass++;
    rom[0] = 24'h000000;
    rst_n = 1'b0;
    #1;
    n_total++; if (halted !== 1'b0) $display("FAIL halt_reset got %b want 0", halted); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    n_total++; if ({pc, halted} !== {12'h001, 1'b0}) $display("FAIL halt_refetch got pc=%h h=%b want 001 0", pc, halted); else n_pass++;
  endtask

  task automatic test_reset_mid_issue();
    rom[0] = 24'h200777;
    issue_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    n_total++; if (issue_valid !== 1'b1) $display("FAIL mid_pre got %b want 1", issue_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({issue_valid, pc_jmp, pc_jmp_addr} !== {1'b0, 1'b1, 12'h000})
      $display("FAIL mid_async got v=%b jmp=%b addr=%h want 0 1 000", issue_valid, pc_jmp, pc_jmp_addr);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++; if ({retired, pc} !== {16'd0, 12'h000}) $display("FAIL mid_after got ret=%0d pc=%h want 0 000", retired, pc); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 24'h000000;
    test_reset();
    test_nop();
    test_issue_stall();
    test_back_to_back();
    test_jmp_wrap();
    test_jz();
    test_self_loop();
    test_halt();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
